// File: rtl/ux607_tl_pkg.sv
// Shared TileLink-UL definitions for the ux607 peripheral bus blocks.
package ux607_tl_pkg;

  localparam int OPCODE_W  = 3;
  localparam int PARAM_W   = 3;
  localparam int D_PARAM_W = 2;
  localparam int SIZE_W    = 3;
  localparam int SOURCE_W  = 2;
  localparam int ADDR_W    = 30;
  localparam int MASK_W    = 4;
  localparam int DATA_W    = 32;

  localparam int SRC_ENTRIES = 4;

  localparam logic [OPCODE_W-1:0] TL_A_PUT_FULL        = 3'd0;
  localparam logic [OPCODE_W-1:0] TL_A_PUT_PARTIAL     = 3'd1;
  localparam logic [OPCODE_W-1:0] TL_A_GET             = 3'd4;
  localparam logic [OPCODE_W-1:0] TL_D_ACCESS_ACK      = 3'd0;
  localparam logic [OPCODE_W-1:0] TL_D_ACCESS_ACK_DATA = 3'd1;

endpackage

// File: rtl/ux607_tl_frag_srctab.sv
// Per-source record of the original A-channel transfer size, used to restore
// d_size on the response. One write port, one combinational read port.
module ux607_tl_frag_srctab
  import ux607_tl_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [SOURCE_W-1:0] wr_idx,
  input  logic [SIZE_W-1:0]   wr_data,
  input  logic [SOURCE_W-1:0] rd_idx,
  output logic [SIZE_W-1:0]   rd_data
);

  logic [SIZE_W-1:0] entry_r [SRC_ENTRIES];

  // Capture the request size for a source; cleared by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SRC_ENTRIES; i++) begin
        entry_r[i] <= '0;
      end
    end else if (wr_en) begin
      entry_r[wr_idx] <= wr_data;
    end
  end

  // No write-to-read bypass: a same-cycle read sees the previous entry.
  assign rd_data = entry_r[rd_idx];

endmodule

// File: rtl/ux607_tl_frag_ctrl.sv
// A-channel fragment sequencer: splits wide Gets into 4-byte Gets for a
// 32-bit slave, holds the upstream repeater via rep_repeat, and restores the
// original size on AccessAckData responses.
module ux607_tl_frag_ctrl
  import ux607_tl_pkg::*;
#(
  parameter int MAX_SIZE = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPCODE_W-1:0]  in_opcode,
  input  logic [PARAM_W-1:0]   in_param,
  input  logic [SIZE_W-1:0]    in_size,
  input  logic [SOURCE_W-1:0]  in_source,
  input  logic [ADDR_W-1:0]    in_address,
  input  logic [MASK_W-1:0]    in_mask,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 rep_repeat,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OPCODE_W-1:0]  out_opcode,
  output logic [PARAM_W-1:0]   out_param,
  output logic [SIZE_W-1:0]    out_size,
  output logic [SOURCE_W-1:0]  out_source,
  output logic [ADDR_W-1:0]    out_address,
  output logic [MASK_W-1:0]    out_mask,
  output logic [DATA_W-1:0]    out_data,
  input  logic                 d_in_valid,
  output logic                 d_in_ready,
  input  logic [OPCODE_W-1:0]  d_in_opcode,
  input  logic [D_PARAM_W-1:0] d_in_param,
  input  logic [SIZE_W-1:0]    d_in_size,
  input  logic [SOURCE_W-1:0]  d_in_source,
  input  logic [DATA_W-1:0]    d_in_data,
  input  logic                 d_in_error,
  output logic                 d_out_valid,
  input  logic                 d_out_ready,
  output logic [OPCODE_W-1:0]  d_out_opcode,
  output logic [D_PARAM_W-1:0] d_out_param,
  output logic [SIZE_W-1:0]    d_out_size,
  output logic [SOURCE_W-1:0]  d_out_source,
  output logic [DATA_W-1:0]    d_out_data,
  output logic                 d_out_error,
  output logic                 err
);

  localparam int                BW         = MAX_SIZE - 2;
  localparam logic [SIZE_W-1:0] MAX_SIZE_L = SIZE_W'(MAX_SIZE);

  logic [BW-1:0]       beat_r;
  logic                err_r;
  logic                fire_s;
  logic                is_get_s;
  logic                frag_s;
  logic                oversize_s;
  logic [SIZE_W-1:0]   size_m2_s;
  logic [BW-1:0]       last_beat_s;
  logic [MAX_SIZE-1:0] addr_keep_s;
  logic [MAX_SIZE-1:0] addr_low_s;
  logic [SIZE_W-1:0]   tab_size_s;

  assign out_valid = in_valid;
  assign in_ready  = out_ready;
  assign fire_s    = out_valid && out_ready;

  assign is_get_s   = (in_opcode == TL_A_GET);
  assign frag_s     = in_valid && is_get_s && (in_size > 3'd2) && (in_size <= MAX_SIZE_L);
  assign oversize_s = is_get_s && (in_size > MAX_SIZE_L);

  // Index of the final fragment, N-1 = 2^(size-2) - 1, as a low-bit mask.
  assign size_m2_s   = in_size - 3'd2;
  assign last_beat_s = ~({BW{1'b1}} << size_m2_s);

  // Offset arithmetic stays inside the low MAX_SIZE address bits.
  assign addr_keep_s = {MAX_SIZE{1'b1}} << in_size;
  assign addr_low_s  = (in_address[MAX_SIZE-1:0] & addr_keep_s) + {beat_r, 2'b00};

  // A-channel field steering: rewrite size/mask/address only for fragmented Gets.
  always_comb begin
    out_opcode  = in_opcode;
    out_param   = in_param;
    out_source  = in_source;
    out_data    = in_data;
    out_size    = in_size;
    out_mask    = in_mask;
    out_address = in_address;
    rep_repeat  = 1'b0;
    if (frag_s) begin
      out_size    = 3'd2;
      out_mask    = 4'hF;
      out_address = {in_address[ADDR_W-1:MAX_SIZE], addr_low_s};
      rep_repeat  = (beat_r != last_beat_s);
    end else begin
      rep_repeat  = 1'b0;
    end
  end

  // Fragment counter: advances on each fragment fire, wraps after the last.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      beat_r <= '0;
    end else if (fire_s && frag_s) begin
      if (beat_r == last_beat_s) begin
        beat_r <= '0;
      end else begin
        beat_r <= beat_r + BW'(1);
      end
    end
  end

  // Sticky flag for Gets too large to fragment.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if (fire_s && oversize_s) begin
      err_r <= 1'b1;
    end
  end

  assign err = err_r;

  ux607_tl_frag_srctab u_srctab (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (fire_s && (beat_r == '0)),
    .wr_idx  (in_source),
    .wr_data (in_size),
    .rd_idx  (d_in_source),
    .rd_data (tab_size_s)
  );

  assign d_out_valid  = d_in_valid;
  assign d_in_ready   = d_out_ready;
  assign d_out_opcode = d_in_opcode;
  assign d_out_param  = d_in_param;
  assign d_out_source = d_in_source;
  assign d_out_data   = d_in_data;
  assign d_out_error  = d_in_error;

  // Data responses report the size the master originally requested.
  always_comb begin
    d_out_size = d_in_size;
    if (d_in_opcode == TL_D_ACCESS_ACK_DATA) begin
      d_out_size = tab_size_s;
    end else begin
      d_out_size = d_in_size;
    end
  end

endmodule

// File: tb/tb_ux607_tl_frag_ctrl.sv
// Scoreboard bench for ux607_tl_frag_ctrl: stimulus pushes expected A/D beats
// from a transaction-level model; a negedge monitor pops and compares.
module tb_ux607_tl_frag_ctrl;

  localparam int MAX_SIZE = 6;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [2:0]  in_opcode = 3'd0, in_param = 3'd0, in_size = 3'd0;
  logic [1:0]  in_source = 2'd0;
  logic [29:0] in_address = 30'd0;
  logic [3:0]  in_mask = 4'd0;
  logic [31:0] in_data = 32'd0;
  logic        rep_repeat, out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  out_opcode, out_param, out_size;
  logic [1:0]  out_source;
  logic [29:0] out_address;
  logic [3:0]  out_mask;
  logic [31:0] out_data;
  logic        d_in_valid = 1'b0, d_in_ready;
  logic [2:0]  d_in_opcode = 3'd0, d_in_size = 3'd0;
  logic [1:0]  d_in_param = 2'd0, d_in_source = 2'd0;
  logic [31:0] d_in_data = 32'd0;
  logic        d_in_error = 1'b0;
  logic        d_out_valid;
  logic        d_out_ready = 1'b0;
  logic [2:0]  d_out_opcode, d_out_size;
  logic [1:0]  d_out_param, d_out_source;
  logic [31:0] d_out_data;
  logic        d_out_error, err;

  always #5 clock = ~clock;

  ux607_tl_frag_ctrl #(.MAX_SIZE(MAX_SIZE)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_param(in_param), .in_size(in_size), .in_source(in_source),
    .in_address(in_address), .in_mask(in_mask), .in_data(in_data),
    .rep_repeat(rep_repeat),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_param(out_param), .out_size(out_size), .out_source(out_source),
    .out_address(out_address), .out_mask(out_mask), .out_data(out_data),
    .d_in_valid(d_in_valid), .d_in_ready(d_in_ready), .d_in_opcode(d_in_opcode),
    .d_in_param(d_in_param), .d_in_size(d_in_size), .d_in_source(d_in_source),
    .d_in_data(d_in_data), .d_in_error(d_in_error),
    .d_out_valid(d_out_valid), .d_out_ready(d_out_ready), .d_out_opcode(d_out_opcode),
    .d_out_param(d_out_param), .d_out_size(d_out_size), .d_out_source(d_out_source),
    .d_out_data(d_out_data), .d_out_error(d_out_error),
    .err(err)
  );

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  param;
    logic [2:0]  size;
    logic [1:0]  src;
    logic [29:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        rep;
  } a_exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  param;
    logic [2:0]  size;
    logic [1:0]  src;
    logic [31:0] data;
    logic        error;
  } d_exp_t;

  a_exp_t     aq[$];
  d_exp_t     dq[$];
  logic [2:0] tbl_m [4];
  logic       err_m = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction model: a fragmentable Get becomes 2^(size-2) word Gets
  // covering the size-aligned block; everything else is one identical beat.
  function automatic int model_a(input logic [2:0] op, input logic [2:0] param,
                                 input logic [2:0] size, input logic [1:0] src,
                                 input logic [29:0] addr, input logic [3:0] mask,
                                 input logic [31:0] data);
    a_exp_t e;
    int n;
    int unsigned blk;
    int unsigned base;
    e.op = op; e.param = param; e.src = src; e.data = data;
    if (op == 3'd4 && size > 3'd2 && int'(size) <= MAX_SIZE) begin
      n    = 1 << (int'(size) - 2);
      blk  = 32'd1 << size;
      base = int'(addr) - (int'(addr) % blk);
      for (int k = 0; k < n; k++) begin
        e.size = 3'd2;
        e.mask = 4'hF;
        e.addr = 30'(base + 4 * k);
        e.rep  = (k != n - 1);
        aq.push_back(e);
      end
    end else begin
      n      = 1;
      e.size = size;
      e.mask = mask;
      e.addr = addr;
      e.rep  = 1'b0;
      aq.push_back(e);
    end
    return n;
  endfunction

  // Drive one A request and hold it until its beats fire (or stop_at fires).
  task automatic send_a(input logic [2:0] op, input logic [2:0] param, input logic [2:0] size,
                        input logic [1:0] src, input logic [29:0] addr, input logic [3:0] mask,
                        input logic [31:0] data, input int mode, input int stop_at);
    int n, limit, fires, cyc;
    n     = model_a(op, param, size, src, addr, mask, data);
    limit = (stop_at > 0 && stop_at < n) ? stop_at : n;
    fires = 0;
    cyc   = 0;
    in_opcode = op; in_param = param; in_size = size; in_source = src;
    in_address = addr; in_mask = mask; in_data = data; in_valid = 1'b1;
    while (fires < limit && cyc < 200) begin
      case (mode)
        0:       out_ready = 1'($urandom_range(0, 1));
        2:       out_ready = (cyc % 2 == 0);
        default: out_ready = 1'b1;
      endcase
      @(posedge clock);
      if (out_ready) begin
        if (fires == 0) tbl_m[src] = size;
        if (op == 3'd4 && int'(size) > MAX_SIZE) err_m = 1'b1;
        fires++;
      end
      #1;
      cyc++;
    end
    if (fires < limit) chk("a_fire_timeout", 64'(fires), 64'(limit));
    if (limit == n) begin
      in_valid  = 1'b0;
      out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // Drive one D response; the expected size comes from the model's table.
  task automatic send_d(input logic [2:0] op, input logic [1:0] param, input logic [2:0] size,
                        input logic [1:0] src, input logic [31:0] data, input logic error);
    d_exp_t e;
    int cyc;
    logic done;
    e.op = op; e.param = param; e.src = src; e.data = data; e.error = error;
    e.size = (op == 3'd1) ? tbl_m[src] : size;
    dq.push_back(e);
    d_in_opcode = op; d_in_param = param; d_in_size = size; d_in_source = src;
    d_in_data = data; d_in_error = error; d_in_valid = 1'b1;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 50) begin
      d_out_ready = 1'($urandom_range(0, 1));
      @(posedge clock);
      done = d_out_ready;
      #1;
      cyc++;
    end
    if (!done) chk("d_fire_timeout", 64'(0), 64'(1));
    d_in_valid  = 1'b0;
    d_out_ready = 1'b0;
  endtask

  // Monitor: compare presented beats against the scoreboard heads.
  always @(negedge clock) begin
    chk("out_valid", 64'(out_valid), 64'(in_valid));
    chk("in_ready", 64'(in_ready), 64'(out_ready));
    chk("d_out_valid", 64'(d_out_valid), 64'(d_in_valid));
    chk("d_in_ready", 64'(d_in_ready), 64'(d_out_ready));
    chk("err", 64'(err), 64'(err_m));
    if (out_valid) begin
      if (aq.size() == 0) begin
        chk("a_unexpected_beat", 64'(1), 64'(0));
      end else begin
        chk("a_opcode", 64'(out_opcode), 64'(aq[0].op));
        chk("a_param", 64'(out_param), 64'(aq[0].param));
        chk("a_size", 64'(out_size), 64'(aq[0].size));
        chk("a_source", 64'(out_source), 64'(aq[0].src));
        chk("a_address", 64'(out_address), 64'(aq[0].addr));
        chk("a_mask", 64'(out_mask), 64'(aq[0].mask));
        chk("a_data", 64'(out_data), 64'(aq[0].data));
        chk("rep_repeat", 64'(rep_repeat), 64'(aq[0].rep));
        if (out_ready) void'(aq.pop_front());
      end
    end else begin
      chk("rep_idle", 64'(rep_repeat), 64'(0));
    end
    if (d_out_valid && d_out_ready) begin
      if (dq.size() == 0) begin
        chk("d_unexpected_beat", 64'(1), 64'(0));
      end else begin
        chk("d_opcode", 64'(d_out_opcode), 64'(dq[0].op));
        chk("d_param", 64'(d_out_param), 64'(dq[0].param));
        chk("d_size", 64'(d_out_size), 64'(dq[0].size));
        chk("d_source", 64'(d_out_source), 64'(dq[0].src));
        chk("d_data", 64'(d_out_data), 64'(dq[0].data));
        chk("d_error", 64'(d_out_error), 64'(dq[0].error));
        void'(dq.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected to finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] op, sz;
    for (int i = 0; i < 4; i++) tbl_m[i] = 3'd0;
    #2 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_err", 64'(err), 64'(0));
    chk("reset_rep", 64'(rep_repeat), 64'(0));
    reset = 1'b0;
    @(posedge clock); #1;

    // Table starts at zero after reset.
    send_d(3'd1, 2'd0, 3'd2, 2'd0, 32'h1111_2222, 1'b0);
    // 16-byte Get, ready held high: 0x10,0x14,0x18,0x1C.
    send_a(3'd4, 3'd0, 3'd4, 2'd2, 30'h14, 4'h3, 32'hDEAD_BEEF, 1, 0);
    // Same Get with out_ready toggling.
    send_a(3'd4, 3'd0, 3'd4, 2'd2, 30'h14, 4'h3, 32'hDEAD_BEEF, 2, 0);
    // Small Put and small Get pass through untouched.
    send_a(3'd0, 3'd0, 3'd2, 2'd0, 30'h2000_0008, 4'hA, 32'hCAFE_F00D, 1, 0);
    send_a(3'd4, 3'd0, 3'd2, 2'd3, 30'h0000_0104, 4'h5, 32'h0, 0, 0);
    // 64-byte Get on source 1, then AckData restores size 6, plain Ack does not.
    send_a(3'd4, 3'd1, 3'd6, 2'd1, 30'h3ABC_D5C4, 4'hF, 32'h0, 0, 0);
    send_d(3'd1, 2'd1, 3'd2, 2'd1, 32'h0BAD_F00D, 1'b0);
    send_d(3'd0, 2'd0, 3'd2, 2'd1, 32'h0, 1'b1);
    chk("dir_tbl_src1", 64'(tbl_m[1]), 64'(6));
    // Oversize Get passes through and sets err.
    send_a(3'd4, 3'd0, 3'd7, 2'd0, 30'h0000_0200, 4'hF, 32'h0, 1, 0);
    @(posedge clock); #1;
    chk("oversize_err", 64'(err), 64'(1));

    // Reset after the second fragment of a 32-byte Get.
    send_a(3'd4, 3'd0, 3'd5, 2'd3, 30'h0000_1234, 4'hF, 32'h7777_0000, 1, 2);
    out_ready = 1'b0;
    reset     = 1'b1;
    #1;
    chk("rst_beat_addr", 64'(out_address), 64'(30'h0000_1220));
    chk("rst_beat_rep", 64'(rep_repeat), 64'(1));
    chk("rst_err", 64'(err), 64'(0));
    in_valid = 1'b0;
    aq.delete();
    err_m = 1'b0;
    for (int i = 0; i < 4; i++) tbl_m[i] = 3'd0;
    send_d(3'd1, 2'd0, 3'd2, 2'd3, 32'h5, 1'b0);
    reset = 1'b0;
    @(posedge clock); #1;
    send_a(3'd4, 3'd0, 3'd3, 2'd3, 30'h0000_1234, 4'hF, 32'h0, 1, 0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      op = ($urandom_range(0, 4) < 2) ? 3'($urandom_range(0, 1)) : 3'd4;
      sz = 3'($urandom_range(0, 7));
      send_a(op, 3'($urandom_range(0, 7)), sz, 2'($urandom_range(0, 3)),
             30'($urandom), 4'($urandom_range(0, 15)), $urandom, int'($urandom_range(0, 2)), 0);
      if ($urandom_range(0, 1) == 1) begin
        send_d(3'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
               2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)));
      end
    end

    repeat (3) @(posedge clock);
    #1;
    chk("a_queue_drained", 64'(aq.size()), 64'(0));
    chk("d_queue_drained", 64'(dq.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
